wb_scheduler: RTL and testbench

//  Write-back scheduler for one 64x32 register file (integer or FP bank, one instance each).

---
 rtl/wb_scheduler_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/wb_scheduler.sv | 131 +++++++++++++
 tb/tb_wb_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_scheduler_pkg.sv
// Shared constants and request type for register-file write-back scheduling.
package wb_scheduler_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_NUM    = 64;
    localparam int ZERO_REG   = 0;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 7;
    localparam int QUERY_N    = 3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer,
// pointer moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] winner;
    logic             found;
    int               idx;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (int'(winner) == N - 1) ? '0 : winner + PTR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// Write-back scheduler: round-robin onto a single register-file write port,
// with a pending-destination scoreboard queried by issue for RAW/WAW stalls.
module wb_scheduler
    import wb_scheduler_pkg::*;
#(
    parameter int NREQ = 3,
    parameter bit FPU  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    output logic                          issue_ready,
    input  logic [QUERY_N*REG_ADDR_W-1:0] query_addr,
    output logic [QUERY_N-1:0]            query_busy,
    input  logic [NREQ-1:0]               wb_valid,
    input  logic [NREQ*REG_ADDR_W-1:0]    wb_addr,
    input  logic [NREQ*DATA_W-1:0]        wb_data,
    output logic [NREQ-1:0]               wb_ready,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic [CNT_W-1:0]              pending_cnt
);

    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    wb_req_t               req [NREQ];
    logic [NREQ-1:0]       arb_req;
    logic [NREQ-1:0]       grant;
    logic                  grant_any;
    logic [REG_ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0]     win_data;

    logic [REG_NUM-1:0]    pend_q, pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic                  issue_set;
    logic                  wb_clear;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i].valid = wb_valid[i];
            req[i].addr  = wb_addr[i*REG_ADDR_W +: REG_ADDR_W];
            req[i].data  = wb_data[i*DATA_W +: DATA_W];
            arb_req[i]   = req[i].valid & ~rst;
        end
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (grant_any),
        .grant   (grant)
    );

    assign grant_any = |grant;
    assign wb_ready  = grant;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_addr = req[i].addr;
                win_data = req[i].data;
            end
        end
    end

    assign issue_ready = ~rst & ~pend_q[issue_rd];
    assign issue_set   = issue_valid & issue_ready & (FPU || (issue_rd != ZERO_ADDR));
    assign wb_clear    = rf_we_q & pend_q[rf_waddr_q];

    // Set is applied after clear so a new producer keeps ownership of the same register.
    always_comb begin
        pend_d = pend_q;
        if (wb_clear) pend_d[rf_waddr_q] = 1'b0;
        if (issue_set) pend_d[issue_rd] = 1'b1;
        cnt_d = cnt_q + CNT_W'(issue_set) - CNT_W'(wb_clear);

        rf_we_d    = grant_any & (FPU || (win_addr != ZERO_ADDR));
        rf_waddr_d = grant_any ? win_addr : rf_waddr_q;
        rf_wdata_d = grant_any ? win_data : rf_wdata_q;
    end

    always_comb begin
        query_busy = '0;
        for (int k = 0; k < QUERY_N; k++) begin
            query_busy[k] = pend_q[query_addr[k*REG_ADDR_W +: REG_ADDR_W]];
        end
    end

    // NOTE: pend_q is a flop vector rather than a RAM, so clearing it in reset is intended.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            cnt_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign pending_cnt = cnt_q;

`ifndef SYNTHESIS
    a_wb_to_pending: assert property (@(posedge clk) disable iff (rst)
        rf_we_q |-> pend_q[rf_waddr_q]);

    for (genvar g = 0; g < NREQ; g++) begin : g_proto
        a_hold_until_grant: assert property (@(posedge clk) disable iff (rst)
            (wb_valid[g] && !wb_ready[g]) |=>
            (wb_valid[g] && $stable(wb_addr[g*REG_ADDR_W +: REG_ADDR_W])
                         && $stable(wb_data[g*DATA_W +: DATA_W])));
    end
`endif

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler; expected register-file writes go through a scoreboard queue.
module tb_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  issue_rd;
    logic [17:0] query_addr;
    logic [2:0]  wb_valid;
    logic [17:0] wb_addr;
    logic [95:0] wb_data;

    logic        issue_ready0, issue_ready1;
    logic [2:0]  query_busy0, query_busy1;
    logic [2:0]  wb_ready0, wb_ready1;
    logic        rf_we0, rf_we1;
    logic [5:0]  rf_waddr0, rf_waddr1;
    logic [31:0] rf_wdata0, rf_wdata1;
    logic [6:0]  cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    wb_scheduler #(.NREQ(3), .FPU(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready0),
        .query_addr(query_addr), .query_busy(query_busy0),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready0),
        .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0), .pending_cnt(cnt0)
    );

    wb_scheduler #(.NREQ(3), .FPU(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready1),
        .query_addr(query_addr), .query_busy(query_busy1),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready1),
        .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1), .pending_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [5:0] addr, input logic [31:0] data);
        wb_addr[i*6 +: 6]   = addr;
        wb_data[i*32 +: 32] = data;
    endtask

    task automatic push(input logic [5:0] addr, input logic [31:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write presented by the int-bank instance must match the next expected one.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rf_we0 === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rf_write", 64'(rf_we0), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rf_waddr", 64'(rf_waddr0), 64'(e.addr));
                check("rf_wdata", 64'(rf_wdata0), 64'(e.data));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic [5:0] cur_addr;
        int w;

        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; query_addr = '0;
        wb_valid = '0; wb_addr = '0; wb_data = '0;

        // Reset cycle: requests present, yet nothing is granted or accepted.
        step();
        wb_valid = 3'b111; issue_rd = 6'd9;
        settle();
        check("rst_wb_ready", 64'(wb_ready0), 64'd0);
        check("rst_issue_ready", 64'(issue_ready0), 64'd0);
        step();
        wb_valid = '0;
        step();
        rst = 1'b0;
        query_addr = {6'd63, 6'd9, 6'd5};
        settle();
        check("rst_rf_we", 64'(rf_we0), 64'd0);
        check("rst_rf_waddr", 64'(rf_waddr0), 64'd0);
        check("rst_rf_wdata", 64'(rf_wdata0), 64'd0);
        check("rst_cnt", 64'(cnt0), 64'd0);
        check("rst_busy", 64'(query_busy0), 64'd0);
        check("post_rst_issue_ready", 64'(issue_ready0), 64'd1);

        // Test 1: reserve rd=5.
        issue_valid = 1'b1; issue_rd = 6'd5;
        settle();
        check("t1_issue_ready", 64'(issue_ready0), 64'd1);
        step();
        issue_valid = 1'b0;
        settle();
        check("t1_busy5", 64'(query_busy0[0]), 64'd1);
        check("t1_cnt", 64'(cnt0), 64'd1);

        // Test 2: write-back of rd=5, busy clears only after the write edge.
        wb_valid = 3'b001; set_req(0, 6'd5, 32'hDEAD_BEEF);
        settle();
        check("t2_wb_ready", 64'(wb_ready0), 64'd1);
        push(6'd5, 32'hDEAD_BEEF);
        step();
        wb_valid = '0;
        settle();
        check("t2_rf_we", 64'(rf_we0), 64'd1);
        check("t2_busy5_during_write", 64'(query_busy0[0]), 64'd1);
        step();
        settle();
        check("t2_busy5_after", 64'(query_busy0[0]), 64'd0);
        check("t2_cnt", 64'(cnt0), 64'd0);
        check("t2_rf_we_idle", 64'(rf_we0), 64'd0);

        // Return the arbiter pointer to 0.
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Test 3: six pending destinations, three requesters held valid.
        issue_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            issue_rd = 6'(10 + k);
            step();
        end
        issue_valid = 1'b0;
        settle();
        check("t3_cnt_after_issue", 64'(cnt0), 64'd6);
        for (int r = 0; r < 3; r++) set_req(r, 6'(10 + r), 32'hC0DE_0000 | 32'(10 + r));
        wb_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            w = k % 3;
            settle();
            if (k > 0) check("t3_rf_we_each_cycle", 64'(rf_we0), 64'd1);
            check("t3_rr_grant", 64'(wb_ready0), 64'd1 << w);
            cur_addr = (k < 3) ? 6'(10 + w) : 6'(13 + w);
            push(cur_addr, 32'hC0DE_0000 | 32'(cur_addr));
            step();
            if (k < 3) set_req(w, 6'(13 + w), 32'hC0DE_0000 | 32'(13 + w));
            else wb_valid[w] = 1'b0;
        end
        step();
        settle();
        check("t3_cnt_drained", 64'(cnt0), 64'd0);
        check("t3_rf_we_idle", 64'(rf_we0), 64'd0);

        // Test 4: WAW stall on rd=7 lasts through the write cycle.
        query_addr = {6'd0, 6'd0, 6'd7};
        issue_valid = 1'b1; issue_rd = 6'd7;
        settle();
        check("t4_first_issue", 64'(issue_ready0), 64'd1);
        step();
        wb_valid = 3'b010; set_req(1, 6'd7, 32'h0000_0777);
        settle();
        check("t4_waw_stall", 64'(issue_ready0), 64'd0);
        check("t4_wb_ready", 64'(wb_ready0), 64'd2);
        push(6'd7, 32'h0000_0777);
        step();
        wb_valid = '0;
        settle();
        check("t4_rf_we", 64'(rf_we0), 64'd1);
        check("t4_stall_in_write_cycle", 64'(issue_ready0), 64'd0);
        step();
        settle();
        check("t4_accept_after_write", 64'(issue_ready0), 64'd1);
        step();
        issue_valid = 1'b0;
        settle();
        check("t4_busy7", 64'(query_busy0[0]), 64'd1);
        check("t4_cnt", 64'(cnt0), 64'd1);

        // Test 5: register 0 on both banks (pointer now at requester 2).
        query_addr = {6'd0, 6'd0, 6'd0};
        issue_valid = 1'b1; issue_rd = 6'd0;
        wb_valid = 3'b100; set_req(2, 6'd0, 32'h0F0F_0F0F);
        settle();
        check("t5_issue_ready0", 64'(issue_ready0), 64'd1);
        check("t5_wb_ready_int", 64'(wb_ready0), 64'd4);
        check("t5_wb_ready_fp", 64'(wb_ready1), 64'd4);
        step();
        issue_valid = 1'b0; wb_valid = '0;
        settle();
        check("t5_int_rf_we", 64'(rf_we0), 64'd0);
        check("t5_int_busy0", 64'(query_busy0[0]), 64'd0);
        check("t5_int_cnt", 64'(cnt0), 64'd1);
        check("t5_fp_rf_we", 64'(rf_we1), 64'd1);
        check("t5_fp_rf_waddr", 64'(rf_waddr1), 64'd0);
        check("t5_fp_rf_wdata", 64'(rf_wdata1), 64'h0F0F_0F0F);
        check("t5_fp_busy0", 64'(query_busy1[0]), 64'd1);
        check("t5_fp_cnt", 64'(cnt1), 64'd2);
        step();
        settle();
        check("t5_fp_busy0_cleared", 64'(query_busy1[0]), 64'd0);
        check("t5_fp_cnt_after", 64'(cnt1), 64'd1);
        check("t5_int_rf_we_after", 64'(rf_we0), 64'd0);

        // Test 6: reset while 3 registers are pending and a write is staged.
        issue_valid = 1'b1; issue_rd = 6'd20;
        step();
        issue_rd = 6'd21;
        wb_valid = 3'b001; set_req(0, 6'd20, 32'h2020_2020);
        settle();
        check("t6_wb_ready", 64'(wb_ready0), 64'd1);
        push(6'd20, 32'h2020_2020);
        step();
        issue_valid = 1'b0; wb_valid = '0; rst = 1'b1; issue_rd = 6'd3;
        settle();
        check("t6_cnt_before_reset", 64'(cnt0), 64'd3);
        check("t6_staged_rf_we", 64'(rf_we0), 64'd1);
        check("t6_issue_ready_in_reset", 64'(issue_ready0), 64'd0);
        step();
        rst = 1'b0;
        query_addr = {6'd21, 6'd20, 6'd7};
        settle();
        check("t6_rf_we_discarded", 64'(rf_we0), 64'd0);
        check("t6_rf_waddr", 64'(rf_waddr0), 64'd0);
        check("t6_rf_wdata", 64'(rf_wdata0), 64'd0);
        check("t6_cnt", 64'(cnt0), 64'd0);
        check("t6_fp_cnt", 64'(cnt1), 64'd0);
        check("t6_busy", 64'(query_busy0), 64'd0);
        wb_valid = 3'b101;
        settle();
        check("t6_rr_ptr_zero", 64'(wb_ready0), 64'd1);
        wb_valid = '0;

        step();
        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
